// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the output FIFO that collects
// per-column partial sums from the MAC array.
package ofifo_pkg;

   localparam int unsigned COL         = 8;
   localparam int unsigned BW_PSUM     = 22;
   localparam int unsigned OFIFO_DEPTH = 8;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int unsigned ptr_width(input int unsigned d);
      return (d < 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/ofifo_lane.sv
// One psum lane: a circular buffer with show-ahead head, occupancy
// count and a drop flag for writes that hit a full buffer.
module ofifo_lane
   import ofifo_pkg::*;
#(
   parameter int unsigned bw    = BW_PSUM,
   parameter int unsigned depth = OFIFO_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [bw-1:0] data,
   input  logic          wr,
   input  logic          rd_en,
   output logic [bw-1:0] head,
   output logic          empty,
   output logic          full,
   output logic          drop
);

   localparam int unsigned aw = ptr_width(depth);
   localparam int unsigned cw = aw + 1;
   localparam logic [cw-1:0] full_cnt = cw'(depth);

   logic [bw-1:0] mem [depth];

   logic [aw-1:0] wr_ptr_q, wr_ptr_d;
   logic [aw-1:0] rd_ptr_q, rd_ptr_d;
   logic [cw-1:0] count_q, count_d;
   logic          push;
   logic          pop;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == full_cnt);
      pop   = rd_en & ~empty;
      // A pop in the same cycle frees the slot the write lands in.
      push  = wr & (~full | pop);
      drop  = wr & full & ~pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) wr_ptr_d = wr_ptr_q + aw'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + aw'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + cw'(1);
         2'b01:   count_d = count_q - cw'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; head is only meaningful while the lane is non-empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= data;
   end

   assign head = mem[rd_ptr_q];

endmodule

// File: rtl/ofifo.sv
// Output FIFO: col independent psum lanes written with per-lane strobes
// and popped together once every lane holds data.
module ofifo
   import ofifo_pkg::*;
#(
   parameter int unsigned col     = COL,
   parameter int unsigned bw_psum = BW_PSUM,
   parameter int unsigned depth   = OFIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col*bw_psum-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [col*bw_psum-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_ovf
);

   logic [col-1:0] empty_vec;
   logic [col-1:0] full_vec;
   logic [col-1:0] drop_vec;
   logic           rd_en;
   logic           ovf_q;

   for (genvar c = 0; c < col; c++) begin : g_lane
      ofifo_lane #(
         .bw    (bw_psum),
         .depth (depth)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .data  (in[c*bw_psum +: bw_psum]),
         .wr    (wr[c]),
         .rd_en (rd_en),
         .head  (out[c*bw_psum +: bw_psum]),
         .empty (empty_vec[c]),
         .full  (full_vec[c]),
         .drop  (drop_vec[c])
      );
   end

   always_comb begin
      o_valid = ~|empty_vec;
      o_full  = |full_vec;
      o_ready = ~o_full;
      // Lanes pop in lockstep so column alignment is preserved.
      rd_en   = rd & o_valid;
      o_ovf   = ovf_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (|drop_vec) begin
         ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo.sv
// Directed self-checking bench for ofifo with default parameters.
module tb_ofifo;

   localparam int COL = 8;
   localparam int BW  = 22;

   logic              clk;
   logic              reset;
   logic [COL*BW-1:0] din;
   logic [COL-1:0]    wr;
   logic              rd;
   logic [COL*BW-1:0] dout;
   logic              o_valid;
   logic              o_full;
   logic              o_ready;
   logic              o_ovf;

   int total = 0;
   int bad   = 0;

   ofifo dut (
      .clk     (clk),
      .reset   (reset),
      .in      (din),
      .wr      (wr),
      .rd      (rd),
      .out     (dout),
      .o_valid (o_valid),
      .o_full  (o_full),
      .o_ready (o_ready),
      .o_ovf   (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [BW-1:0] lane_of(input logic [COL*BW-1:0] v, input int c);
      return v[c*BW +: BW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int c, input int val);
      din[c*BW +: BW] = BW'(val);
   endtask

   task automatic do_reset();
      wr    = '0;
      rd    = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   // Writes k*10+c into every lane for k = 0..7.
   task automatic fill_all();
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < COL; c++) set_lane(c, k * 10 + c);
         wr = '1;
         step();
      end
      wr = '0;
   endtask

   task automatic test_reset();
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
      total++;
      if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", o_full); end
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
      total++;
      if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", o_ovf); end
   endtask

   task automatic test_skewed_fill();
      do_reset();
      for (int c = 0; c < COL; c++) begin
         set_lane(c, 100 + c);
         wr = COL'(1) << c;
         step();
         if (c == COL - 2) begin
            total++;
            if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_valid_early got=%b want=0", o_valid); end
         end
      end
      wr = '0;
      total++;
      if (o_valid !== 1'b1) begin bad++; $display("FAIL skew_valid got=%b want=1", o_valid); end
      for (int c = 0; c < COL; c++) begin
         total++;
         if (lane_of(dout, c) !== BW'(100 + c)) begin
            bad++; $display("FAIL skew_lane%0d got=%0d want=%0d", c, lane_of(dout, c), 100 + c);
         end
      end
   endtask

   task automatic test_fill_drain();
      do_reset();
      fill_all();
      total++;
      if (o_full !== 1'b1) begin bad++; $display("FAIL fd_full got=%b want=1", o_full); end
      total++;
      if (o_ready !== 1'b0) begin bad++; $display("FAIL fd_ready got=%b want=0", o_ready); end
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < COL; c++) begin
            total++;
            if (lane_of(dout, c) !== BW'(k * 10 + c)) begin
               bad++; $display("FAIL fd_k%0d_lane%0d got=%0d want=%0d", k, c, lane_of(dout, c), k * 10 + c);
            end
         end
         rd = 1'b1;
         step();
      end
      rd = 1'b0;
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL fd_empty got=%b want=0", o_valid); end
      total++;
      if (o_ovf !== 1'b0) begin bad++; $display("FAIL fd_ovf got=%b want=0", o_ovf); end
      // rd while empty must be ignored: a single write afterwards is the new head.
      rd = 1'b1;
      step();
      rd = 1'b0;
      for (int c = 0; c < COL; c++) set_lane(c, 300 + c);
      wr = '1;
      step();
      wr = '0;
      total++;
      if (lane_of(dout, 3) !== BW'(303) || o_valid !== 1'b1) begin
         bad++; $display("FAIL fd_rd_empty got=%0d/%b want=303/1", lane_of(dout, 3), o_valid);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      fill_all();
      set_lane(0, 999);
      wr = 8'h01;
      step();
      wr = '0;
      total++;
      if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", o_ovf); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (lane_of(dout, 0) !== BW'(k * 10)) begin
            bad++; $display("FAIL ovf_lane0_k%0d got=%0d want=%0d", k, lane_of(dout, 0), k * 10);
         end
         rd = 1'b1;
         step();
      end
      rd = 1'b0;
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", o_valid); end
      step();
      step();
      total++;
      if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", o_ovf); end
      do_reset();
      total++;
      if (o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", o_ovf); end
   endtask

   task automatic test_concurrent_full();
      do_reset();
      fill_all();
      for (int c = 0; c < COL; c++) set_lane(c, 500 + c);
      wr = '1;
      rd = 1'b1;
      step();
      wr = '0;
      rd = 1'b0;
      total++;
      if (o_full !== 1'b1) begin bad++; $display("FAIL cf_full got=%b want=1", o_full); end
      total++;
      if (o_ovf !== 1'b0) begin bad++; $display("FAIL cf_ovf got=%b want=0", o_ovf); end
      for (int k = 1; k <= 8; k++) begin
         for (int c = 0; c < COL; c++) begin
            int exp_v;
            exp_v = (k == 8) ? 500 + c : k * 10 + c;
            total++;
            if (lane_of(dout, c) !== BW'(exp_v)) begin
               bad++; $display("FAIL cf_k%0d_lane%0d got=%0d want=%0d", k, c, lane_of(dout, c), exp_v);
            end
         end
         rd = 1'b1;
         step();
      end
      rd = 1'b0;
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL cf_empty got=%b want=0", o_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int c = 0; c < COL; c++) set_lane(c, c);
      wr = '1;
      step();
      for (int i = 0; i < 20; i++) begin
         for (int c = 0; c < COL; c++) begin
            total++;
            if (lane_of(dout, c) !== BW'(i * 16 + c)) begin
               bad++; $display("FAIL wrap_i%0d_lane%0d got=%0d want=%0d", i, c, lane_of(dout, c), i * 16 + c);
            end
         end
         for (int c = 0; c < COL; c++) set_lane(c, (i + 1) * 16 + c);
         wr = '1;
         rd = 1'b1;
         step();
      end
      wr = '0;
      rd = 1'b0;
      total++;
      if (lane_of(dout, 5) !== BW'(20 * 16 + 5)) begin
         bad++; $display("FAIL wrap_last got=%0d want=%0d", lane_of(dout, 5), 20 * 16 + 5);
      end
      total++;
      if (o_ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", o_ovf); end
      rd = 1'b1;
      step();
      rd = 1'b0;
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL wrap_one_left got=%b want=0", o_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < COL; c++) set_lane(c, 40 + k);
         wr = '1;
         step();
      end
      wr = '0;
      total++;
      if (o_valid !== 1'b1) begin bad++; $display("FAIL rm_loaded got=%b want=1", o_valid); end
      #3;
      reset = 1'b1;
      #1;
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_async got=%b want=0", o_valid); end
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", o_ready); end
      reset = 1'b0;
      #1;
      for (int c = 0; c < COL; c++) set_lane(c, 7);
      wr = '1;
      step();
      wr = '0;
      total++;
      if (o_valid !== 1'b1) begin bad++; $display("FAIL rm_new_valid got=%b want=1", o_valid); end
      for (int c = 0; c < COL; c++) begin
         total++;
         if (lane_of(dout, c) !== BW'(7)) begin
            bad++; $display("FAIL rm_head_lane%0d got=%0d want=7", c, lane_of(dout, c));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      din   = '0;
      wr    = '0;
      rd    = 1'b0;
      #3;
      test_reset();
      step();
      reset = 1'b0;
      test_skewed_fill();
      test_fill_drain();
      test_overflow();
      test_concurrent_full();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 Parameter col, default 8: number of psum lanes, one per mac_array column.
REQ-002 Parameter bw_psum, default 22: width of each psum lane in bits.
REQ-003 Parameter depth, default 8: entries per lane; SHALL be a power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: reset is asynchronous and active-high.
REQ-006 Port in, input, col*bw_psum: psum data; lane c is in[c*bw_psum +: bw_psum].
REQ-007 Port wr, input, col: per-lane write strobe; wr[c] qualifies lane c of in.
REQ-008 Port rd, input, 1: pop one entry from every lane at once.
REQ-009 Port out, output, col*bw_psum: head entry of each lane, packed the same way as in.
REQ-010 Port o_valid, output, 1: every lane holds at least one entry.
REQ-011 Port o_full, output, 1: at least one lane is full.
REQ-012 Port o_ready, output, 1: no lane is full.
REQ-013 Port o_ovf, output, 1: sticky overflow error.

Function
REQ-014 Each lane SHALL be an independent circular buffer of depth entries, with a write pointer, a read pointer and an occupancy count of width log2(depth)+1.
REQ-015 Write: on a clock edge with wr[c]=1 and lane c not full, the lane SHALL store its slice of in at the write pointer and increment the write pointer modulo depth.
REQ-016 A write to a full lane SHALL be dropped, leaving data and pointers unchanged, and SHALL set o_ovf to 1 from the next cycle.
REQ-017 Combinational outputs:
- o_valid = AND over lanes of (count != 0).
- o_full = OR over lanes of (count == depth).
- o_ready = NOT o_full.
REQ-018 out SHALL be show-ahead: each lane slice is combinationally the entry at that lane's read pointer.
REQ-019 out SHALL be meaningful only while o_valid=1.
REQ-020 Read: on a clock edge with rd=1 and o_valid=1, every lane SHALL advance its read pointer modulo depth and decrement its count.
REQ-021 rd while o_valid=0 SHALL be ignored; no lane changes state.
REQ-022 Simultaneous write and accepted read on the same lane SHALL both take effect and leave that lane's count unchanged.
- This holds for a full lane: the write is accepted and o_ovf is not set.
- This holds for a lane with count 1: the old head is popped and the new entry becomes the head.
REQ-023 Lanes MAY be written in different cycles, as with the skewed column outputs of mac_array.
REQ-024 Alignment: lane c's k-th write SHALL be popped by the k-th accepted read.
REQ-025 Pointers SHALL wrap from depth-1 to 0 with no bubble cycle.

Reset
REQ-026 While reset=1, all pointers and counts SHALL be 0 and o_ovf SHALL be 0.
REQ-027 While reset=1, outputs SHALL be o_valid=0, o_full=0, o_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock.
REQ-029 Storage array contents need not be reset; out is don't-care while o_valid=0.
REQ-030 Writes and reads on the first edge after reset deassertion SHALL be honoured normally.

Structure
REQ-031 Shared package SHALL hold the defaults COL=8, BW_PSUM=22, OFIFO_DEPTH=8, and a function returning the pointer width for a given depth.
REQ-032 One sub-module, ofifo_lane, SHALL implement a single lane: inputs data, wr, rd_en; outputs head, empty, full, drop.
REQ-033 ofifo SHALL instantiate col copies of ofifo_lane via generate.
REQ-034 ofifo SHALL form the AND/OR reductions, drive every lane's rd_en with rd & o_valid, and OR the drop outputs into the o_ovf sticky register.

Verification
REQ-035 Skewed fill: wr[c] pulses at cycle c for c=0..7, lane c data = 100+c -> o_valid rises the cycle after the lane-7 write; out lanes read 100..107.
REQ-036 Fill and drain: write all lanes 8 times with value k*10+c (k=0..7) -> o_full=1 and o_ready=0; then rd on 8 consecutive cycles -> out returns k=0..7 in order, then o_valid=0.
REQ-037 Overflow: with all lanes full, wr=8'h01 with rd=0 -> lane 0 unchanged, o_ovf=1 and stays 1 until reset.
REQ-038 Concurrent access on full lane: all lanes full, wr=8'hFF with rd=1 -> counts stay 8, o_ovf stays 0, oldest entry popped.
REQ-039 Wrap-around: 20 cycles of simultaneous single write and read after priming one entry -> data order preserved across pointer wrap, no drop.
REQ-040 Reset mid-stream: reset asserted between clock edges with 5 entries per lane -> o_valid=0 immediately; after release a new write of 7 appears as head.
